alu_nibble_sequencer: RTL

Multi-cycle controller that executes one WIDTH-bit ALU operation on a single external 4-bit ALU slice (74381-style: A, B, S, Cin in; F, G, P out), one nibble per cycle, LSB nibble first. It sits directly around the slice: upstream it drives operands, select and carry-in; downstream it consumes F/G/P, ripples the carry and assembles the full-width result and flags. Replaces a wide slice chain with one slice plus sequencing.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_nibble_mux.sv | 28 ++
 rtl/alu_nibble_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared select codes and sequencer state encoding for the nibble-serial ALU controller.
package alu_pkg;

  localparam logic [2:0] ALU_CLR = 3'b000;
  localparam logic [2:0] ALU_BMA = 3'b001;
  localparam logic [2:0] ALU_AMB = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_SET = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_nibble_mux.sv
// Combinational selection of the current 4-bit operand nibbles, indexed LSB nibble first.
module alu_nibble_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IDX_W-1:0] idx,
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b
);

  localparam int NIB = WIDTH / 4;

  always_comb begin
    nib_a = a[3:0];
    nib_b = b[3:0];
    for (int i = 1; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_a = a[i*4 +: 4];
        nib_b = b[i*4 +: 4];
      end
    end
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs one WIDTH-bit operation through a single external 4-bit ALU slice, one nibble per cycle.
// Optional signed-overflow output is enabled by defining OVERFLOW_FLAG_EN.
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_s,
  input  logic             op_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic [2:0]       slice_s,
  output logic             slice_cin,
  input  logic [3:0]       slice_f,
  input  logic             slice_g,
  input  logic             slice_p
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [2:0]       s_lat;
  logic             carry;
  logic             carry_next;
  logic             last;
  logic [WIDTH-1:0] result_next;

`ifdef OVERFLOW_FLAG_EN
  function automatic logic overflow_calc(input logic [2:0] s, input logic a_msb,
                                         input logic b_msb, input logic f_msb);
    logic ovf;
    case (s)
      ALU_ADD: ovf = (a_msb == b_msb) && (f_msb != a_msb);
      ALU_AMB: ovf = (a_msb != b_msb) && (f_msb != a_msb);
      ALU_BMA: ovf = (a_msb != b_msb) && (f_msb != b_msb);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction
`endif

  alu_nibble_mux #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_mux (
    .a     (a_lat),
    .b     (b_lat),
    .idx   (idx),
    .nib_a (slice_a),
    .nib_b (slice_b)
  );

  assign slice_s    = s_lat;
  assign slice_cin  = carry;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign zero       = (result == '0);
  assign negative   = result[WIDTH-1];
  assign carry_next = slice_g | (slice_p & carry);
  assign last       = (idx == LAST_IDX);

  always_comb begin
    result_next = result;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        result_next[i*4 +: 4] = slice_f;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture in IDLE, nibble-serial carry ripple and result assembly in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      s_lat     <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_lat <= op_a;
            b_lat <= op_b;
            s_lat <= op_s;
            carry <= op_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          result <= result_next;
          carry  <= carry_next;
          if (last) begin
            // Park idx at 0 so the slice sees nibble 0 outside RUN, whatever NIB is.
            idx       <= '0;
            carry_out <= carry_next;
`ifdef OVERFLOW_FLAG_EN
            overflow  <= overflow_calc(s_lat, a_lat[WIDTH-1], b_lat[WIDTH-1], slice_f[3]);
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
